// File: rtl/main_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V main controller: states, opcodes,
// datapath select codes and the decoded control bundle.
package main_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_EXECL    = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_RES = 1'b1;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational state-to-control decoder (Moore outputs).
// EXECL decode exists only when MAIN_CTRL_FSM_UPPER_IMM_EN is defined.
module main_ctrl_outdec
  import main_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      STATE_W'(S_FETCH): begin
        ctrl.adr_src    = ADR_PC;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURES;
        ctrl.pc_update  = 1'b1;
      end
      STATE_W'(S_DECODE): begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      STATE_W'(S_MEMADR): begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      STATE_W'(S_MEMREAD): begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = ADR_RES;
      end
      STATE_W'(S_MEMWB): begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      STATE_W'(S_MEMWRITE): begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = ADR_RES;
        ctrl.mem_write  = 1'b1;
      end
      STATE_W'(S_EXECR): begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(S_EXECI): begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      STATE_W'(S_JAL): begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      STATE_W'(S_BEQ): begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
`ifdef MAIN_CTRL_FSM_UPPER_IMM_EN
      STATE_W'(S_EXECL): begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle RISC-V main control FSM: state register, next-state logic,
// illegal-opcode pulse and reset gating. lui/auipc need MAIN_CTRL_FSM_UPPER_IMM_EN.
module main_ctrl_fsm
  import main_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       pc_update,
  output logic       branch,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(S_MEMREAD);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(S_MEMWRITE);
  localparam logic [STATE_W-1:0] EXECR    = STATE_W'(S_EXECR);
  localparam logic [STATE_W-1:0] EXECI    = STATE_W'(S_EXECI);
  localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] JAL      = STATE_W'(S_JAL);
  localparam logic [STATE_W-1:0] BEQ      = STATE_W'(S_BEQ);
  localparam logic [STATE_W-1:0] EXECL    = STATE_W'(S_EXECL);

  logic [STATE_W-1:0] state, state_nxt, dec_state;
  logic               ill_q, ill_nxt;
  ctrl_t              dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ill_q <= ill_nxt;
    end
  end

  // Terminal states and unreachable encodings all fall back to FETCH.
  always_comb begin
    state_nxt = FETCH;
    ill_nxt   = 1'b0;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_JAL:            state_nxt = JAL;
          OP_BEQ:            state_nxt = BEQ;
`ifdef MAIN_CTRL_FSM_UPPER_IMM_EN
          OP_LUI:            state_nxt = EXECL;
          OP_AUIPC:          state_nxt = ALUWB;  // ALUOut already holds OldPC+imm
`endif
          default:           ill_nxt   = 1'b1;
        endcase
      end
      MEMADR:       state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:      state_nxt = MEMWB;
      EXECR, EXECI: state_nxt = ALUWB;
      JAL:          state_nxt = ALUWB;
`ifdef MAIN_CTRL_FSM_UPPER_IMM_EN
      EXECL:        state_nxt = ALUWB;
`endif
      default:      state_nxt = FETCH;
    endcase
  end

  // During reset the selects show FETCH values and every write enable is held low.
  assign dec_state = reset ? FETCH : state;

  main_ctrl_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state (dec_state),
    .ctrl  (dec)
  );

  assign pc_update  = dec.pc_update & ~reset;
  assign branch     = dec.branch    & ~reset;
  assign ir_write   = dec.ir_write  & ~reset;
  assign reg_write  = dec.reg_write & ~reset;
  assign mem_write  = dec.mem_write & ~reset;
  assign adr_src    = dec.adr_src;
  assign alu_src_a  = dec.alu_src_a;
  assign alu_src_b  = dec.alu_src_b;
  assign result_src = dec.result_src;
  assign alu_op     = dec.alu_op;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Scoreboard bench for main_ctrl_fsm: the driver queues hand-written per-cycle
// expectations, a negedge monitor pops and compares the full control vector.
module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic       pc_update, branch, ir_write, reg_write, mem_write, adr_src, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;

  main_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .pc_update  (pc_update),
    .branch     (branch),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] JL = 7'b1101111, BQ = 7'b1100011, LU = 7'b0110111, AU = 7'b0010111;
  localparam logic [6:0] BAD = 7'b0000000;

  typedef struct {
    string       name;
    logic [14:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          passes = 0;
  logic [14:0] act;

  // {pc_update, branch, ir_write, reg_write, mem_write, adr_src, src_a, src_b, result_src, alu_op, illegal_op}
  assign act = {pc_update, branch, ir_write, reg_write, mem_write, adr_src,
                alu_src_a, alu_src_b, result_src, alu_op, illegal_op};

  function automatic logic [14:0] mk(input bit pc, br, ir, rw, mw, adr,
                                     input logic [1:0] a, b, res, ao);
    return {pc, br, ir, rw, mw, adr, a, b, res, ao, 1'b0};
  endfunction

  logic [14:0] E_RST, E_F, E_FI, E_D, E_MA, E_MR, E_MWB, E_MW, E_ER, E_EI, E_AWB, E_J, E_B, E_EL;

  task automatic cyc(input bit r, input logic [6:0] o, input logic [14:0] e, input string n);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r;
    op    = o;
    x.name = n;
    x.exp  = e;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      checks++;
      if (act === x.exp) passes++;
      else $display("FAIL %s: got %b required %b", x.name, act, x.exp);
    end
  end

  always @(negedge clk)
    assert (!(pc_update && branch)) else $error("pc_update and branch both high");

  initial begin
    E_RST = mk(0,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00);
    E_F   = mk(1,0,1,0,0,0, 2'b00,2'b10,2'b10,2'b00);
    E_FI  = E_F | 15'd1;
    E_D   = mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00);
    E_MA  = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00);
    E_MR  = mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00);
    E_MWB = mk(0,0,0,1,0,0, 2'b00,2'b00,2'b01,2'b00);
    E_MW  = mk(0,0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00);
    E_ER  = mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10);
    E_EI  = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10);
    E_AWB = mk(0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00);
    E_J   = mk(1,0,0,0,0,0, 2'b01,2'b10,2'b00,2'b00);
    E_B   = mk(0,1,0,0,0,0, 2'b10,2'b00,2'b00,2'b01);
    E_EL  = mk(0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00);

    repeat (3) cyc(1, LW, E_RST, "reset hold");
    cyc(0, LW, E_F,   "lw F");
    cyc(0, LW, E_D,   "lw D");
    cyc(0, LW, E_MA,  "lw MEMADR");
    cyc(0, LW, E_MR,  "lw MEMREAD");
    cyc(0, LW, E_MWB, "lw MEMWB");
    cyc(0, SW, E_F,   "sw F");
    cyc(0, SW, E_D,   "sw D");
    cyc(0, SW, E_MA,  "sw MEMADR");
    cyc(0, SW, E_MW,  "sw MEMWRITE");
    cyc(0, BQ, E_F,   "beq F");
    cyc(0, BQ, E_D,   "beq D");
    cyc(0, BQ, E_B,   "beq BEQ");
    cyc(0, JL, E_F,   "jal F");
    cyc(0, JL, E_D,   "jal D");
    cyc(0, JL, E_J,   "jal JAL");
    cyc(0, JL, E_AWB, "jal ALUWB");
    cyc(0, RT, E_F,   "rtype F");
    cyc(0, RT, E_D,   "rtype D");
    cyc(0, RT, E_ER,  "rtype EXECR");
    cyc(0, RT, E_AWB, "rtype ALUWB");
    cyc(0, IT, E_F,   "itype F");
    cyc(0, IT, E_D,   "itype D");
    cyc(0, IT, E_EI,  "itype EXECI");
    cyc(0, IT, E_AWB, "itype ALUWB");
`ifdef MAIN_CTRL_FSM_UPPER_IMM_EN
    cyc(0, LU, E_F,   "lui F");
    cyc(0, LU, E_D,   "lui D");
    cyc(0, LU, E_EL,  "lui EXECL");
    cyc(0, LU, E_AWB, "lui ALUWB");
    cyc(0, AU, E_F,   "auipc F");
    cyc(0, AU, E_D,   "auipc D");
    cyc(0, AU, E_AWB, "auipc ALUWB");
    cyc(0, BQ, E_F,   "beq F after auipc");
`else
    cyc(0, LU, E_F,   "lui F");
    cyc(0, LU, E_D,   "lui D");
    cyc(0, BQ, E_FI,  "F illegal after lui");
    cyc(0, BQ, E_D,   "beq D after lui");
    cyc(0, BQ, E_B,   "beq BEQ after lui");
    cyc(0, AU, E_F,   "auipc F no pulse");
    cyc(0, AU, E_D,   "auipc D");
    cyc(0, BQ, E_FI,  "F illegal after auipc");
`endif
    cyc(0, BQ, E_D,   "beq D 2");
    cyc(0, BQ, E_B,   "beq BEQ 2");
    cyc(0, BAD, E_F,  "bad F");
    cyc(0, BAD, E_D,  "bad D");
    cyc(0, SW, E_FI,  "F illegal after bad op");
    cyc(0, SW, E_D,   "sw D 2");
    cyc(0, SW, E_MA,  "sw MEMADR 2");
    cyc(1, SW, E_RST, "reset in MEMWRITE");
    cyc(0, SW, E_F,   "F after mid reset");
    cyc(0, SW, E_D,   "sw D 3");
    cyc(0, SW, E_MA,  "sw MEMADR 3");
    cyc(0, LW, E_MW,  "sw MEMWRITE 3");
    cyc(0, LW, E_F,   "lw F 2");
    cyc(0, LW, E_D,   "lw D 2");
    cyc(0, LW, E_MA,  "lw MEMADR 2");
    cyc(0, BQ, E_MR,  "lw MEMREAD op toggled");
    cyc(0, JL, E_MWB, "lw MEMWB op toggled");
    cyc(0, BQ, E_F,   "beq F 3");

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d pending, required 0", sbq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
